uart_rx_framed: RTL

UART_RX_FRAMED -- requirements
Module: uart_rx_framed

---
 rtl/uart_rx_framed.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framed.sv
// Framed UART receiver: 3-flop synchronizer, start/data/parity/stop FSM with
// break and framing detection, and a small receive FIFO with overrun pulse.
module uart_rx_framed #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 rdata_perr,
  output logic                 rdata_ferr,
  output logic                 rdata_valid,
  input  logic                 rdata_ready,
  output logic                 overrun,
  output logic                 brk
);

  localparam int unsigned CntW  = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = AddrW + 1;
  localparam int unsigned EntW  = DATA_BITS + 2;

  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);
  localparam logic [OccW-1:0] FullOcc  = OccW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } state_e;

  logic [2:0]           sync_q;
  logic                 rx_s;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 ferr_q, ferr_d;
  logic                 one_q, one_d;
  logic                 push_q, push_d;
  logic                 brk_q, brk_d;
  logic [EntW-1:0]      entry_q, entry_d;
  logic                 half_done, bit_done;
  logic                 par_x, perr_now, stop_ferr, stop_one;

  logic [EntW-1:0]      mem_q [FIFO_DEPTH];
  logic [AddrW-1:0]     wr_q, rd_q;
  logic [OccW-1:0]      count_q;
  logic                 overrun_q;
  logic                 fifo_full, pop, do_push;
  logic [EntW-1:0]      head;

  assign rx_s = sync_q[2];

  // Synchronize the asynchronous serial line; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], rxd};
    end
  end

  // Receiver state and frame-assembly registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      ferr_q    <= 1'b0;
      one_q     <= 1'b0;
      push_q    <= 1'b0;
      brk_q     <= 1'b0;
      entry_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      ferr_q    <= ferr_d;
      one_q     <= one_d;
      push_q    <= push_d;
      brk_q     <= brk_d;
      entry_q   <= entry_d;
    end
  end

  // Next-state: sample mid-bit, assemble the frame, flag break/framing errors.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    ferr_d    = ferr_q;
    one_d     = one_q;
    push_d    = 1'b0;
    brk_d     = 1'b0;
    entry_d   = entry_q;
    half_done = (cnt_q == HalfLast);
    bit_done  = (cnt_q == BitLast);
    stop_ferr = ferr_q | ~rx_s;
    stop_one  = one_q | rx_s;
    par_x     = (^shift_q) ^ par_q;
    if (PARITY == 1) begin
      perr_now = ~par_x;
    end else if (PARITY == 2) begin
      perr_now = par_x;
    end else begin
      perr_now = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s) begin
          state_d   = StStart;
          bit_cnt_d = '0;
          par_d     = 1'b0;
          ferr_d    = 1'b0;
          one_d     = 1'b0;
        end
      end
      StStart: begin
        if (half_done) begin
          cnt_d   = '0;
          state_d = rx_s ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          one_d   = one_q | rx_s;
          if (bit_cnt_q == DataLast) begin
            bit_cnt_d = '0;
            state_d   = (PARITY == 0) ? StStop : StParity;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          cnt_d   = '0;
          par_d   = rx_s;
          one_d   = one_q | rx_s;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_done) begin
          cnt_d  = '0;
          ferr_d = stop_ferr;
          one_d  = stop_one;
          if (bit_cnt_q == StopLast) begin
            if (!stop_one) begin
              // Every sample low: a break, not a character.
              brk_d   = 1'b1;
              state_d = StWaitHigh;
            end else begin
              push_d  = 1'b1;
              entry_d = {shift_q, perr_now, stop_ferr};
              state_d = stop_ferr ? StWaitHigh : StIdle;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rdata_valid = (count_q != '0);
  assign fifo_full   = (count_q == FullOcc);
  assign pop         = rdata_valid & rdata_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push     = push_q & (~fifo_full | pop);

  // FIFO pointers, occupancy and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + AddrW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + AddrW'(1);
      end
      if (do_push && !pop) begin
        count_q <= count_q + OccW'(1);
      end else if (!do_push && pop) begin
        count_q <= count_q - OccW'(1);
      end
      overrun_q <= push_q & fifo_full & ~pop;
    end
  end

  // FIFO storage; contents need no reset since occupancy gates the outputs.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[wr_q] <= entry_q;
    end
  end

  assign head       = mem_q[rd_q];
  assign rdata      = rdata_valid ? head[EntW-1:2] : '0;
  assign rdata_perr = rdata_valid & head[1];
  assign rdata_ferr = rdata_valid & head[0];
  assign overrun    = overrun_q;
  assign brk        = brk_q;

endmodule
